cpu_ctrl_fsm: RTL and testbench
===============================

Name: cpu_ctrl_fsm

Overview:
- Multicycle control unit for the 16-bit CPU datapath.
- Sequences fetch, decode, execute, memory and writeback.
- Drives every datapath mux select (reg_in, alu_1, alu_2, addr_sel, pc_sel, reg_w_sel) and every register/memory enable, from the latched IR and the ALU flags.
- Handshakes with the memory/I-O bus using a ready signal.

Parameters:
- ILLEGAL_HALT, 0: 0 means an undefined opcode executes as a NOP; 1 means it enters HALT.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- ir  in  16  instruction register contents (valid from DECODE onward)
- flag_z  in  1  registered zero flag
- flag_n  in  1  registered negative flag
- mem_ready  in  1  memory/I-O access complete this cycle
- reg_in  out  3  register write-data select: 0 ALU, 1 MDR, 2 opB, 3 imm8 sign-extended, 4 mvhi, 5 PC
- alu_1  out  1  ALU A select: 0 PC, 1 opA
- alu_2  out  2  ALU B select: 0 const 2, 1 opB, 2 imm11<<1, 3 imm8
- alu_op  out  2  ALU operation: 0 add, 1 sub
- addr_sel  out  1  memory address select: 0 PC, 1 opB
- pc_sel  out  1  PC source: 0 ALU, 1 opA
- reg_w_sel  out  1  write register: 0 ir[7:5], 1 R7
- ir_we, pc_we, reg_we, flag_we, op_we, mdr_we  out  1 each  load enables
- mem_rd, mem_wr  out  1 each  bus read/write request
- halted  out  1  high while in HALT
- illegal  out  1  one-cycle pulse when an undefined opcode is decoded

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset: state goes to FETCH. All enables, mem_rd, mem_wr, halted and illegal go to 0. All selects go to 0.
- Outputs are decoded combinationally from state and ir.
- Instruction fields: opcode ir[3:0]; imm flag ir[4]; Rx ir[7:5]; Ry ir[10:8].
- Opcodes:
  - 0 mv, 1 add, 2 sub, 3 cmp, 4 ld, 5 st, 6 mvhi
  - 8 j, 9 jz, 10 jn, 12 call
  - 15 halt
  - all others undefined
- FETCH:
  - Drive addr_sel=0, mem_rd=1.
  - Hold mem_rd until mem_ready.
  - In the mem_ready cycle: ir_we=1, pc_we=1 with alu_1=0, alu_2=0, alu_op=add, pc_sel=0 (PC+2). Go to DECODE.
- DECODE:
  - op_we=1 (latch opA=Rx, opB=Ry).
  - Next state: ld/st go to MEM; halt goes to HALT; undefined pulses illegal and goes to FETCH (or HALT if ILLEGAL_HALT); all others go to EXEC.
- EXEC:
  - mv: reg_in = imm ? 3 : 2; reg_we=1.
  - add/sub: reg_in=0, alu_1=1, alu_2 = imm ? 3 : 1, alu_op as opcode; reg_we=1; flag_we=1.
  - cmp: as sub, but reg_we=0.
  - mvhi: reg_in=4; reg_we=1.
  - j: pc_we=1. imm form uses alu_1=0, alu_2=2, pc_sel=0. Register form uses pc_sel=1.
  - jz/jn: as j, with pc_we gated by flag_z / flag_n.
  - call: reg_in=5, reg_w_sel=1, reg_we=1 (R7 = PC, already +2), plus the j target update.
  - Go to FETCH.
- MEM:
  - addr_sel=1. mem_rd=1 for ld; mem_wr=1 for st (data = opA).
  - Hold until mem_ready.
  - ld: mdr_we=1 in the ready cycle, then go to WB.
  - st: go to FETCH.
- WB: reg_in=1, reg_we=1, go to FETCH.
- HALT: sticky; halted=1; no enables asserted. Left only by reset.
- Latency with zero-wait memory (mem_ready in the first cycle): 3 cycles for ALU, branch and st instructions; 4 cycles for ld. Each wait cycle adds 1.
- Request and write rules:
  - mem_rd/mem_wr never both high.
  - Requests stay stable until mem_ready.
  - reg_we and pc_we are never asserted outside their listed cycles.
- Reset mid-access: requests drop immediately (asynchronously). Execution restarts at FETCH.

Decomposition:
- Package cpu_ctrl_pkg holds:
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT)
  - opcode constants
  - select-encoding constants for reg_in, alu_1, alu_2, addr_sel, pc_sel, reg_w_sel, alu_op
- One sub-module, cpu_ctrl_decode: combinational map from {state, ir, flags, mem_ready} to control outputs. The top holds only the state register and next-state logic.

Test Plan:
- Reset, then release with mem_ready=1 and ir=0x0301 (add R0,R3) → FETCH, DECODE, EXEC over 3 cycles. EXEC shows alu_1=1, alu_2=1, reg_we=1, flag_we=1.
- ld (ir=0x0104) with mem_ready low 2 cycles in MEM → mem_rd and addr_sel=1 held 3 cycles. mdr_we in the ready cycle, then WB with reg_in=1. Total 6 cycles.
- jz imm (ir=0xFFF9, opcode 9 with imm flag) with flag_z=0 → no pc_we in EXEC. With flag_z=1 → pc_we=1, alu_2=2, pc_sel=0.
- call register form (opcode 12, ir[4]=0) → EXEC has reg_in=5, reg_w_sel=1, reg_we=1, pc_sel=1, pc_we=1.
- Opcode 7 with ILLEGAL_HALT=0 → illegal pulse 1 cycle, then FETCH. With ILLEGAL_HALT=1 → halted=1 held for 20 cycles.
- reset_n low mid-MEM of st → mem_wr drops in the same cycle. After release, the first access is a FETCH read.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the multicycle CPU control unit.
// States, opcodes and datapath select codes live here.
package cpu_ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    WB,
    HALT
  } state_e;

  localparam logic [3:0] OP_MV   = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_LD   = 4'd4;
  localparam logic [3:0] OP_ST   = 4'd5;
  localparam logic [3:0] OP_MVHI = 4'd6;
  localparam logic [3:0] OP_J    = 4'd8;
  localparam logic [3:0] OP_JZ   = 4'd9;
  localparam logic [3:0] OP_JN   = 4'd10;
  localparam logic [3:0] OP_CALL = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [2:0] RIN_ALU  = 3'd0;
  localparam logic [2:0] RIN_MDR  = 3'd1;
  localparam logic [2:0] RIN_OPB  = 3'd2;
  localparam logic [2:0] RIN_IMM8 = 3'd3;
  localparam logic [2:0] RIN_MVHI = 3'd4;
  localparam logic [2:0] RIN_PC   = 3'd5;

  localparam logic A1_PC  = 1'b0;
  localparam logic A1_OPA = 1'b1;

  localparam logic [1:0] A2_TWO   = 2'd0;
  localparam logic [1:0] A2_OPB   = 2'd1;
  localparam logic [1:0] A2_IMM11 = 2'd2;
  localparam logic [1:0] A2_IMM8  = 2'd3;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_SUB = 2'd1;

  localparam logic ADDR_PC  = 1'b0;
  localparam logic ADDR_OPB = 1'b1;

  localparam logic PC_ALU = 1'b0;
  localparam logic PC_OPA = 1'b1;

  localparam logic RW_RX = 1'b0;
  localparam logic RW_R7 = 1'b1;

  typedef struct packed {
    logic [2:0] reg_in;
    logic       alu_1;
    logic [1:0] alu_2;
    logic [1:0] alu_op;
    logic       addr_sel;
    logic       pc_sel;
    logic       reg_w_sel;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       flag_we;
    logic       op_we;
    logic       mdr_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       illegal;
  } ctl_t;

  function automatic logic op_legal(logic [3:0] op);
    case (op)
      OP_MV, OP_ADD, OP_SUB, OP_CMP,
      OP_LD, OP_ST, OP_MVHI, OP_J,
      OP_JZ, OP_JN, OP_CALL, OP_HALT:
        op_legal = 1'b1;
      default:
        op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_if.sv
// Control bundle between the control FSM and the datapath / bus.
// master = control unit, slave = datapath and memory side.
interface cpu_ctrl_fsm_if;

  logic [15:0] ir;
  logic        flag_z;
  logic        flag_n;
  logic        mem_ready;
  logic [2:0]  reg_in;
  logic        alu_1;
  logic [1:0]  alu_2;
  logic [1:0]  alu_op;
  logic        addr_sel;
  logic        pc_sel;
  logic        reg_w_sel;
  logic        ir_we;
  logic        pc_we;
  logic        reg_we;
  logic        flag_we;
  logic        op_we;
  logic        mdr_we;
  logic        mem_rd;
  logic        mem_wr;
  logic        halted;
  logic        illegal;

  modport master (
    input  ir, flag_z, flag_n, mem_ready,
    output reg_in, alu_1, alu_2, alu_op,
    output addr_sel, pc_sel, reg_w_sel,
    output ir_we, pc_we, reg_we, flag_we,
    output op_we, mdr_we, mem_rd, mem_wr,
    output halted, illegal
  );

  modport slave (
    output ir, flag_z, flag_n, mem_ready,
    input  reg_in, alu_1, alu_2, alu_op,
    input  addr_sel, pc_sel, reg_w_sel,
    input  ir_we, pc_we, reg_we, flag_we,
    input  op_we, mdr_we, mem_rd, mem_wr,
    input  halted, illegal
  );

endinterface

// File: rtl/cpu_ctrl_decode.sv
// Combinational control decode from state, opcode, flags and ready.
// Everything is forced low while reset is asserted.
module cpu_ctrl_decode
  import cpu_ctrl_pkg::*;
(
  input  logic       rst_n_i,
  input  state_e     state_i,
  input  logic [3:0] op_i,
  input  logic       imm_i,
  input  logic       flag_z_i,
  input  logic       flag_n_i,
  input  logic       mem_ready_i,
  output ctl_t       ctl_o
);

  logic is_jmp;
  logic take;

  always_comb begin
    is_jmp = (op_i == OP_J) || (op_i == OP_JZ) ||
             (op_i == OP_JN) || (op_i == OP_CALL);
    take = (op_i == OP_J) || (op_i == OP_CALL) ||
           ((op_i == OP_JZ) && flag_z_i) ||
           ((op_i == OP_JN) && flag_n_i);
  end

  always_comb begin
    ctl_o = '0;
    if (rst_n_i) begin
      unique case (state_i)
        FETCH: begin
          ctl_o.addr_sel = ADDR_PC;
          ctl_o.mem_rd   = 1'b1;
          ctl_o.ir_we    = mem_ready_i;
          ctl_o.pc_we    = mem_ready_i;
        end
        DECODE: begin
          ctl_o.op_we   = 1'b1;
          ctl_o.illegal = !op_legal(op_i);
        end
        EXEC: begin
          unique case (1'b1)
            (op_i == OP_MV): begin
              ctl_o.reg_in = imm_i ? RIN_IMM8 : RIN_OPB;
              ctl_o.reg_we = 1'b1;
            end
            (op_i == OP_ADD),
            (op_i == OP_SUB),
            (op_i == OP_CMP): begin
              ctl_o.reg_in  = RIN_ALU;
              ctl_o.alu_1   = A1_OPA;
              ctl_o.alu_2   = imm_i ? A2_IMM8 : A2_OPB;
              ctl_o.alu_op  = (op_i == OP_ADD) ? ALU_ADD : ALU_SUB;
              ctl_o.reg_we  = (op_i != OP_CMP);
              ctl_o.flag_we = 1'b1;
            end
            (op_i == OP_MVHI): begin
              ctl_o.reg_in = RIN_MVHI;
              ctl_o.reg_we = 1'b1;
            end
            is_jmp: begin
              ctl_o.alu_1  = A1_PC;
              ctl_o.alu_2  = imm_i ? A2_IMM11 : A2_TWO;
              ctl_o.pc_sel = imm_i ? PC_ALU : PC_OPA;
              ctl_o.pc_we  = take;
              // call links the already-incremented PC into R7
              if (op_i == OP_CALL) begin
                ctl_o.reg_in    = RIN_PC;
                ctl_o.reg_w_sel = RW_R7;
                ctl_o.reg_we    = 1'b1;
              end
            end
            default: ;
          endcase
        end
        MEM: begin
          ctl_o.addr_sel = ADDR_OPB;
          ctl_o.mem_rd   = (op_i == OP_LD);
          ctl_o.mem_wr   = (op_i == OP_ST);
          ctl_o.mdr_we   = (op_i == OP_LD) && mem_ready_i;
        end
        WB: begin
          ctl_o.reg_in = RIN_MDR;
          ctl_o.reg_we = 1'b1;
        end
        HALT: ctl_o.halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multicycle control FSM: state register and next-state logic.
// Control outputs come from the cpu_ctrl_decode instance.
module cpu_ctrl_fsm
  import cpu_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic           clk,
  input  logic           reset_n,
  cpu_ctrl_fsm_if.master bus
);

  state_e     state_q, state_d;
  ctl_t       ctl;
  logic [3:0] op;

  assign op = bus.ir[3:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= FETCH;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:  if (bus.mem_ready) state_d = DECODE;
      DECODE: begin
        unique case (1'b1)
          (op == OP_LD), (op == OP_ST): state_d = MEM;
          (op == OP_HALT):              state_d = HALT;
          (!op_legal(op)):
            state_d = ILLEGAL_HALT ? HALT : FETCH;
          default:                      state_d = EXEC;
        endcase
      end
      EXEC: state_d = FETCH;
      MEM: begin
        if (bus.mem_ready)
          state_d = (op == OP_LD) ? WB : FETCH;
      end
      WB:   state_d = FETCH;
      HALT: state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  cpu_ctrl_decode u_dec (
    .rst_n_i     (reset_n),
    .state_i     (state_q),
    .op_i        (op),
    .imm_i       (bus.ir[4]),
    .flag_z_i    (bus.flag_z),
    .flag_n_i    (bus.flag_n),
    .mem_ready_i (bus.mem_ready),
    .ctl_o       (ctl)
  );

  assign bus.reg_in    = ctl.reg_in;
  assign bus.alu_1     = ctl.alu_1;
  assign bus.alu_2     = ctl.alu_2;
  assign bus.alu_op    = ctl.alu_op;
  assign bus.addr_sel  = ctl.addr_sel;
  assign bus.pc_sel    = ctl.pc_sel;
  assign bus.reg_w_sel = ctl.reg_w_sel;
  assign bus.ir_we     = ctl.ir_we;
  assign bus.pc_we     = ctl.pc_we;
  assign bus.reg_we    = ctl.reg_we;
  assign bus.flag_we   = ctl.flag_we;
  assign bus.op_we     = ctl.op_we;
  assign bus.mdr_we    = ctl.mdr_we;
  assign bus.mem_rd    = ctl.mem_rd;
  assign bus.mem_wr    = ctl.mem_wr;
  assign bus.halted    = ctl.halted;
  assign bus.illegal   = ctl.illegal;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Directed bench for cpu_ctrl_fsm with a per-cycle expected-output queue.
// A second instance with ILLEGAL_HALT=1 covers the halting variant.
module tb_cpu_ctrl_fsm;

  typedef struct packed {
    logic [2:0] reg_in;
    logic       alu_1;
    logic [1:0] alu_2;
    logic [1:0] alu_op;
    logic       addr_sel;
    logic       pc_sel;
    logic       reg_w_sel;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic       flag_we;
    logic       op_we;
    logic       mdr_we;
    logic       mem_rd;
    logic       mem_wr;
    logic       halted;
    logic       illegal;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];
  exp_t e;

  cpu_ctrl_fsm_if bus0 ();
  cpu_ctrl_fsm_if bus1 ();

  cpu_ctrl_fsm #(.ILLEGAL_HALT(1'b0)) dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  cpu_ctrl_fsm #(.ILLEGAL_HALT(1'b1)) dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  always #5 clk = ~clk;

  function automatic exp_t obs();
    exp_t o;
    o.reg_in    = bus0.reg_in;
    o.alu_1     = bus0.alu_1;
    o.alu_2     = bus0.alu_2;
    o.alu_op    = bus0.alu_op;
    o.addr_sel  = bus0.addr_sel;
    o.pc_sel    = bus0.pc_sel;
    o.reg_w_sel = bus0.reg_w_sel;
    o.ir_we     = bus0.ir_we;
    o.pc_we     = bus0.pc_we;
    o.reg_we    = bus0.reg_we;
    o.flag_we   = bus0.flag_we;
    o.op_we     = bus0.op_we;
    o.mdr_we    = bus0.mdr_we;
    o.mem_rd    = bus0.mem_rd;
    o.mem_wr    = bus0.mem_wr;
    o.halted    = bus0.halted;
    o.illegal   = bus0.illegal;
    return o;
  endfunction

  function automatic exp_t f_fetch(logic rdy);
    exp_t x = '0;
    x.mem_rd = 1'b1;
    x.ir_we  = rdy;
    x.pc_we  = rdy;
    return x;
  endfunction

  function automatic exp_t f_dec(logic ill);
    exp_t x = '0;
    x.op_we   = 1'b1;
    x.illegal = ill;
    return x;
  endfunction

  task automatic set_in(logic [15:0] ir, logic z, logic n, logic rdy);
    bus0.ir = ir;  bus0.flag_z = z;  bus0.flag_n = n;  bus0.mem_ready = rdy;
    bus1.ir = ir;  bus1.flag_z = z;  bus1.flag_n = n;  bus1.mem_ready = rdy;
  endtask

  task automatic check(string tag, int h1);
    exp_t want;
    exp_t got;
    want = q.pop_front();
    got  = obs();
    n_chk++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %h want %h", tag, got, want);
    end
    if (h1 >= 0) begin
      n_chk++;
      assert (bus1.halted === h1[0]) else begin
        n_fail++;
        $error("FAIL %s_halted1: got %b want %b", tag, bus1.halted, h1[0]);
      end
    end
  endtask

  task automatic cyc(string tag, exp_t x, int h1 = -1);
    q.push_back(x);
    @(negedge clk);
    check(tag, h1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    set_in(16'h0301, 1'b0, 1'b0, 1'b1);
    cyc("reset", '0, 0);
    reset_n = 1'b1;

    cyc("add_fetch", f_fetch(1'b1));
    cyc("add_dec", f_dec(1'b0));
    e = '0; e.alu_1 = 1'b1; e.alu_2 = 2'd1;
    e.reg_we = 1'b1; e.flag_we = 1'b1;
    cyc("add_exec", e);

    set_in(16'h0113, 1'b0, 1'b0, 1'b0);
    cyc("cmp_fwait", f_fetch(1'b0));
    bus0.mem_ready = 1'b1; bus1.mem_ready = 1'b1;
    cyc("cmp_fetch", f_fetch(1'b1));
    cyc("cmp_dec", f_dec(1'b0));
    e = '0; e.alu_1 = 1'b1; e.alu_2 = 2'd3;
    e.alu_op = 2'd1; e.flag_we = 1'b1;
    cyc("cmp_exec", e);

    set_in(16'h0104, 1'b0, 1'b0, 1'b1);
    cyc("ld_fetch", f_fetch(1'b1));
    cyc("ld_dec", f_dec(1'b0));
    bus0.mem_ready = 1'b0; bus1.mem_ready = 1'b0;
    e = '0; e.addr_sel = 1'b1; e.mem_rd = 1'b1;
    cyc("ld_mwait1", e);
    cyc("ld_mwait2", e);
    bus0.mem_ready = 1'b1; bus1.mem_ready = 1'b1;
    e.mdr_we = 1'b1;
    cyc("ld_mready", e);
    e = '0; e.reg_in = 3'd1; e.reg_we = 1'b1;
    cyc("ld_wb", e);

    set_in(16'hFFF9, 1'b0, 1'b0, 1'b1);
    cyc("jz0_fetch", f_fetch(1'b1));
    cyc("jz0_dec", f_dec(1'b0));
    e = '0; e.alu_2 = 2'd2;
    cyc("jz0_exec", e);
    set_in(16'hFFF9, 1'b1, 1'b0, 1'b1);
    cyc("jz1_fetch", f_fetch(1'b1));
    cyc("jz1_dec", f_dec(1'b0));
    e.pc_we = 1'b1;
    cyc("jz1_exec", e);

    set_in(16'h000C, 1'b0, 1'b0, 1'b1);
    cyc("call_fetch", f_fetch(1'b1));
    cyc("call_dec", f_dec(1'b0));
    e = '0; e.reg_in = 3'd5; e.reg_w_sel = 1'b1;
    e.reg_we = 1'b1; e.pc_sel = 1'b1; e.pc_we = 1'b1;
    cyc("call_exec", e);

    set_in(16'h0007, 1'b0, 1'b0, 1'b1);
    cyc("ill_fetch", f_fetch(1'b1), 0);
    cyc("ill_dec", f_dec(1'b1), 0);
    for (int i = 0; i < 10; i++) begin
      cyc("ill_refetch", f_fetch(1'b1), 1);
      cyc("ill_redec", f_dec(1'b1), 1);
    end

    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    set_in(16'h0105, 1'b0, 1'b0, 1'b1);
    cyc("st_fetch", f_fetch(1'b1), 0);
    cyc("st_dec", f_dec(1'b0));
    bus0.mem_ready = 1'b0; bus1.mem_ready = 1'b0;
    e = '0; e.addr_sel = 1'b1; e.mem_wr = 1'b1;
    cyc("st_mwait", e);
    reset_n = 1'b0;
    #1;
    q.push_back('0);
    check("st_rst_drop", 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus0.mem_ready = 1'b1; bus1.mem_ready = 1'b1;
    cyc("st_refetch", f_fetch(1'b1));

    n_chk++;
    assert (q.size() == 0) else begin
      n_fail++;
      $error("FAIL sb_empty: got %0d want 0", q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
